// File: rtl/adres_cozucu_pkg.sv
// Shared types and defaults for the load/store address decoder.
// Region codes are packed with channel 0 in the lowest field.
package adres_cozucu_pkg;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ERISIM = 2'd1,
    YANIT  = 2'd2
  } durum_t;

  // ch0=0, ch1=1, ch2=2, ch3=4
  localparam logic [11:0] VARSAYILAN_BOLGE =
    {3'd4, 3'd2, 3'd1, 3'd0};

  localparam int VARSAYILAN_ZAMAN_ASIMI = 255;

endpackage

// File: rtl/adres_bolge_eslestirici.sv
// Region-field comparator: one-hot hit vector, lowest channel wins.
// Purely combinational.
module adres_bolge_eslestirici #(
  parameter int KANAL = 4,
  parameter int S     = 3
) (
  input  logic [S-1:0]       alan_i,
  input  logic [KANAL*S-1:0] kodlar_i,
  output logic [KANAL-1:0]   isabet_o,
  output logic               herhangi_o
);

  logic bulundu;

  always_comb begin
    isabet_o = '0;
    bulundu  = 1'b0;
    for (int k = 0; k < KANAL; k++) begin
      if (!bulundu && (kodlar_i[k*S +: S] == alan_i)) begin
        isabet_o[k] = 1'b1;
        bulundu     = 1'b1;
      end
    end
    herhangi_o = bulundu;
  end

endmodule

// File: rtl/adres_cozucu.sv
// Registered address decoder: one request in flight, per-target
// valid/ready handshake, error on unmapped address or timeout.
module adres_cozucu
  import adres_cozucu_pkg::*;
#(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int KANAL       = 4,
  parameter int SECIM_MSB   = 30,
  parameter int SECIM_LSB   = 28,
  parameter logic [KANAL*(SECIM_MSB-SECIM_LSB+1)-1:0]
    BOLGE_KODLARI = VARSAYILAN_BOLGE,
  parameter int ZAMAN_ASIMI = VARSAYILAN_ZAMAN_ASIMI
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      istek_gecerli_i,
  output logic                      istek_hazir_o,
  input  logic [ADRES_BIT-1:0]      istek_adres_i,
  input  logic                      istek_yaz_i,
  input  logic [VERI_BIT-1:0]       istek_veri_i,
  input  logic [VERI_BIT/8-1:0]     istek_maske_i,
  output logic                      yanit_gecerli_o,
  output logic [VERI_BIT-1:0]       yanit_veri_o,
  output logic                      yanit_hata_o,
  output logic [KANAL-1:0]          kanal_gecerli_o,
  output logic                      kanal_yaz_o,
  output logic [ADRES_BIT-1:0]      kanal_adres_o,
  output logic [VERI_BIT-1:0]       kanal_veri_o,
  output logic [VERI_BIT/8-1:0]     kanal_maske_o,
  input  logic [KANAL-1:0]          kanal_hazir_i,
  input  logic [KANAL*VERI_BIT-1:0] kanal_veri_i
);

  localparam int S  = SECIM_MSB - SECIM_LSB + 1;
  localparam int MB = VERI_BIT / 8;
  localparam int SAYAC_BIT =
    (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam int SON =
    (ZAMAN_ASIMI > 0) ? ZAMAN_ASIMI - 1 : 0;

  durum_t durum_q, durum_d;

  logic [KANAL-1:0]     secim_q;
  logic                 yaz_q;
  logic [ADRES_BIT-1:0] adres_q;
  logic [VERI_BIT-1:0]  veri_q;
  logic [MB-1:0]        maske_q;
  logic [SAYAC_BIT-1:0] sayac_q;
  logic [VERI_BIT-1:0]  yveri_q;
  logic                 yhata_q;

  logic [KANAL-1:0]    isabet;
  logic                isabet_var;
  logic                kabul;
  logic                hazir_sec;
  logic                zaman_doldu;
  logic [VERI_BIT-1:0] secilen_veri;

  adres_bolge_eslestirici #(
    .KANAL (KANAL),
    .S     (S)
  ) u_eslestirici (
    .alan_i     (istek_adres_i[SECIM_MSB:SECIM_LSB]),
    .kodlar_i   (BOLGE_KODLARI),
    .isabet_o   (isabet),
    .herhangi_o (isabet_var)
  );

  assign kabul     = (durum_q == BOSTA) && istek_gecerli_i;
  assign hazir_sec = |(kanal_hazir_i & secim_q);

  // Zero disables the timeout entirely.
  assign zaman_doldu = (ZAMAN_ASIMI != 0) &&
                       (sayac_q == SAYAC_BIT'(SON));

  always_comb begin
    secilen_veri = '0;
    for (int k = 0; k < KANAL; k++) begin
      if (secim_q[k]) begin
        secilen_veri = secilen_veri |
                       kanal_veri_i[k*VERI_BIT +: VERI_BIT];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      BOSTA: begin
        if (istek_gecerli_i) begin
          durum_d = isabet_var ? ERISIM : YANIT;
        end
      end
      ERISIM: begin
        if (hazir_sec || zaman_doldu) begin
          durum_d = YANIT;
        end
      end
      YANIT:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    istek_hazir_o   = 1'b0;
    yanit_gecerli_o = 1'b0;
    yanit_veri_o    = '0;
    yanit_hata_o    = 1'b0;
    kanal_gecerli_o = '0;
    unique case (1'b1)
      (durum_q == BOSTA):  istek_hazir_o = 1'b1;
      (durum_q == ERISIM): kanal_gecerli_o = secim_q;
      (durum_q == YANIT): begin
        yanit_gecerli_o = 1'b1;
        yanit_veri_o    = yveri_q;
        yanit_hata_o    = yhata_q;
      end
      default: ;
    endcase
  end

  // Hazir wins over the final timeout cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      secim_q <= '0;
      yaz_q   <= 1'b0;
      adres_q <= '0;
      veri_q  <= '0;
      maske_q <= '0;
      sayac_q <= '0;
      yveri_q <= '0;
      yhata_q <= 1'b0;
    end else if (kabul) begin
      secim_q <= isabet;
      yaz_q   <= istek_yaz_i;
      adres_q <= istek_adres_i;
      veri_q  <= istek_veri_i;
      maske_q <= istek_maske_i;
      sayac_q <= '0;
      yveri_q <= '0;
      yhata_q <= !isabet_var;
    end else if (durum_q == ERISIM) begin
      sayac_q <= sayac_q + SAYAC_BIT'(1);
      if (hazir_sec) begin
        yhata_q <= 1'b0;
        yveri_q <= yaz_q ? '0 : secilen_veri;
      end else if (zaman_doldu) begin
        yhata_q <= 1'b1;
      end
    end
  end

  assign kanal_yaz_o   = yaz_q;
  assign kanal_adres_o = adres_q;
  assign kanal_veri_o  = veri_q;
  assign kanal_maske_o = maske_q;

endmodule

// File: tb/tb_adres_cozucu.sv
// Directed bench for adres_cozucu with response scoreboards.
// Second instance uses duplicate region codes.
module tb_adres_cozucu;

  typedef struct {
    int          cyc;
    logic [31:0] veri;
    logic        hata;
  } beklenen_t;

  logic clk = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  beklenen_t q1[$];
  beklenen_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         gec, yaz, hazir_o, y_gec, y_hata, k_yaz;
  logic [31:0]  adres, veri, y_veri, k_adres, k_veri_o;
  logic [3:0]   maske, k_gec, k_maske, k_hazir;
  logic [127:0] k_veri;

  logic         b_gec, b_hazir_o, b_y_gec, b_y_hata, b_k_yaz;
  logic [31:0]  b_adres, b_y_veri, b_k_adres, b_k_veri_o;
  logic [3:0]   b_k_gec, b_k_maske, b_k_hazir;
  logic [127:0] b_k_veri;

  adres_cozucu #(
    .ZAMAN_ASIMI (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .istek_gecerli_i (gec),
    .istek_hazir_o   (hazir_o),
    .istek_adres_i   (adres),
    .istek_yaz_i     (yaz),
    .istek_veri_i    (veri),
    .istek_maske_i   (maske),
    .yanit_gecerli_o (y_gec),
    .yanit_veri_o    (y_veri),
    .yanit_hata_o    (y_hata),
    .kanal_gecerli_o (k_gec),
    .kanal_yaz_o     (k_yaz),
    .kanal_adres_o   (k_adres),
    .kanal_veri_o    (k_veri_o),
    .kanal_maske_o   (k_maske),
    .kanal_hazir_i   (k_hazir),
    .kanal_veri_i    (k_veri)
  );

  adres_cozucu #(
    .BOLGE_KODLARI ({3'd4, 3'd5, 3'd1, 3'd5}),
    .ZAMAN_ASIMI   (8)
  ) dut2 (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .istek_gecerli_i (b_gec),
    .istek_hazir_o   (b_hazir_o),
    .istek_adres_i   (b_adres),
    .istek_yaz_i     (1'b0),
    .istek_veri_i    (32'h0),
    .istek_maske_i   (4'hF),
    .yanit_gecerli_o (b_y_gec),
    .yanit_veri_o    (b_y_veri),
    .yanit_hata_o    (b_y_hata),
    .kanal_gecerli_o (b_k_gec),
    .kanal_yaz_o     (b_k_yaz),
    .kanal_adres_o   (b_k_adres),
    .kanal_veri_o    (b_k_veri_o),
    .kanal_maske_o   (b_k_maske),
    .kanal_hazir_i   (b_k_hazir),
    .kanal_veri_i    (b_k_veri)
  );

  task automatic kontrol(string ad, logic [63:0] g,
                         logic [63:0] b);
    n_assert++;
    assert (g === b) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", ad, g, b);
    end
  endtask

  always @(negedge clk) begin
    if (y_gec) begin
      if (q1.size() == 0) begin
        kontrol("sahte_yanit", 64'd1, 64'd0);
      end else begin
        beklenen_t e;
        e = q1.pop_front();
        kontrol("yanit_cyc", 64'(cyc), 64'(e.cyc));
        kontrol("yanit_veri", 64'(y_veri), 64'(e.veri));
        kontrol("yanit_hata", 64'(y_hata), 64'(e.hata));
      end
    end
  end

  always @(negedge clk) begin
    if (b_y_gec) begin
      if (q2.size() == 0) begin
        kontrol("b_sahte_yanit", 64'd1, 64'd0);
      end else begin
        beklenen_t e;
        e = q2.pop_front();
        kontrol("b_yanit_cyc", 64'(cyc), 64'(e.cyc));
        kontrol("b_yanit_veri", 64'(b_y_veri), 64'(e.veri));
        kontrol("b_yanit_hata", 64'(b_y_hata), 64'(e.hata));
      end
    end
  end

  // Called at posedge+1 in the issue cycle; returns one cycle later.
  task automatic istek(logic [31:0] a, logic w, logic [31:0] d,
                       logic [3:0] m, logic [31:0] ev,
                       logic eh, int gec_sure, bit push);
    adres = a;
    yaz   = w;
    veri  = d;
    maske = m;
    gec   = 1'b1;
    kontrol("istek_hazir", 64'(hazir_o), 64'd1);
    if (push) q1.push_back('{cyc + gec_sure, ev, eh});
    @(posedge clk); #1;
    gec = 1'b0;
  endtask

  task automatic bekle();
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk); #1;
    end
    kontrol("bekleme", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    rst_i = 1'b0;
    gec = 0; yaz = 0; adres = 0; veri = 0; maske = 0;
    k_hazir = 0; k_veri = '0;
    b_gec = 0; b_adres = 0; b_k_hazir = 0; b_k_veri = '0;
    repeat (3) @(posedge clk);
    #1;
    kontrol("rst_hazir", 64'(hazir_o), 64'd1);
    kontrol("rst_ygec", 64'(y_gec), 64'd0);
    kontrol("rst_kgec", 64'(k_gec), 64'd0);
    kontrol("rst_kadres", 64'(k_adres), 64'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    // read hit on ch3, target ready immediately
    k_veri[3*32 +: 32] = 32'hDEAD_BEEF;
    k_hazir = 4'b1000;
    istek(32'h4000_0010, 0, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 2, 1);
    kontrol("t1_kgec", 64'(k_gec), 64'b1000);
    kontrol("t1_kadres", 64'(k_adres), 64'h4000_0010);
    kontrol("t1_kyaz", 64'(k_yaz), 64'd0);
    bekle();
    k_hazir = 0;

    // write to ch2, ready on third access cycle
    k_veri[2*32 +: 32] = 32'hFFFF_FFFF;
    istek(32'h2000_0004, 1, 32'h1234_5678, 4'b0011, 32'h0, 0, 4, 1);
    for (int i = 0; i < 3; i++) begin
      kontrol("t2_kgec", 64'(k_gec), 64'b0100);
      kontrol("t2_kveri", 64'(k_veri_o), 64'h1234_5678);
      kontrol("t2_kmaske", 64'(k_maske), 64'b0011);
      kontrol("t2_kyaz", 64'(k_yaz), 64'd1);
      kontrol("t2_hazir0", 64'(hazir_o), 64'd0);
      if (i == 2) k_hazir = 4'b0100;
      @(posedge clk); #1;
    end
    k_hazir = 0;
    kontrol("t2_kgec_son", 64'(k_gec), 64'd0);
    bekle();

    // unmapped, then back-to-back second miss
    istek(32'h7000_0000, 0, 32'h0, 4'hF, 32'h0, 1, 1, 1);
    kontrol("t3_kgec", 64'(k_gec), 64'd0);
    kontrol("t3_yanit_hazir", 64'(hazir_o), 64'd0);
    @(posedge clk); #1;
    istek(32'h3000_0000, 0, 32'h0, 4'hF, 32'h0, 1, 1, 1);
    bekle();

    // timeout on ch1
    istek(32'h1000_0000, 0, 32'h0, 4'hF, 32'h0, 1, 9, 1);
    for (int i = 0; i < 8; i++) begin
      kontrol("t4_kgec", 64'(k_gec), 64'b0010);
      @(posedge clk); #1;
    end
    kontrol("t4_dusus", 64'(k_gec), 64'd0);
    bekle();

    // ready on the last allowed cycle completes normally
    k_veri[1*32 +: 32] = 32'hA5A5_0001;
    istek(32'h1000_0020, 0, 32'h0, 4'hF, 32'hA5A5_0001, 0, 9, 1);
    for (int i = 0; i < 8; i++) begin
      kontrol("t4b_kgec", 64'(k_gec), 64'b0010);
      if (i == 7) k_hazir = 4'b0010;
      @(posedge clk); #1;
    end
    k_hazir = 0;
    bekle();

    // reset in the middle of an access
    istek(32'h0000_0100, 1, 32'hCAFE, 4'hF, 32'h0, 0, 0, 0);
    kontrol("t5_kgec", 64'(k_gec), 64'b0001);
    rst_i = 1'b0;
    @(posedge clk); #1;
    kontrol("t5_hazir", 64'(hazir_o), 64'd1);
    kontrol("t5_ygec", 64'(y_gec), 64'd0);
    kontrol("t5_yveri", 64'(y_veri), 64'd0);
    kontrol("t5_yhata", 64'(y_hata), 64'd0);
    kontrol("t5_kgec0", 64'(k_gec), 64'd0);
    kontrol("t5_kadres", 64'(k_adres), 64'd0);
    kontrol("t5_kveri", 64'(k_veri_o), 64'd0);
    kontrol("t5_kyaz", 64'(k_yaz), 64'd0);
    rst_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bekle();

    // duplicate codes: ch0 wins, ch2 ready ignored
    b_k_veri[0*32 +: 32] = 32'h0BAD_F00D;
    b_k_veri[2*32 +: 32] = 32'h1111_2222;
    b_adres = 32'h5000_0000;
    b_gec = 1'b1;
    kontrol("t6_hazir", 64'(b_hazir_o), 64'd1);
    q2.push_back('{cyc + 4, 32'h0BAD_F00D, 1'b0});
    @(posedge clk); #1;
    b_gec = 1'b0;
    kontrol("t6_kgec1", 64'(b_k_gec), 64'b0001);
    b_k_hazir = 4'b0100;
    @(posedge clk); #1;
    kontrol("t6_kgec2", 64'(b_k_gec), 64'b0001);
    @(posedge clk); #1;
    kontrol("t6_kgec3", 64'(b_k_gec), 64'b0001);
    b_k_hazir = 4'b0001;
    @(posedge clk); #1;
    b_k_hazir = 0;
    bekle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
